id_ex_reg: RTL and testbench

//  ID->EX pipeline register of the ARM core; feeds the EX stage (Val2 generator, ALU, branch adder).

---
 rtl/id_ex_reg.sv | 170 +++++++++++++++++
 tb/tb_id_ex_reg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_reg
//  Description : ID->EX pipeline register with hold (stall) and bubble
//                (flush) select, plus a valid bit marking real instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg #(
    parameter int DATA_W  = 32,
    parameter int SHOP_W  = 12,
    parameter int IMM24_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               valid_in,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic [DATA_W-1:0]  val_rn_in,
    input  logic [DATA_W-1:0]  val_rm_in,
    input  logic [SHOP_W-1:0]  shift_operand_in,
    input  logic               imm_in,
    input  logic [IMM24_W-1:0] imm24_in,
    input  logic [3:0]         dest_in,
    input  logic [3:0]         src1_in,
    input  logic [3:0]         src2_in,
    input  logic [3:0]         exe_cmd_in,
    input  logic               mem_r_in,
    input  logic               mem_w_in,
    input  logic               wb_en_in,
    input  logic               b_in,
    input  logic               s_in,
    input  logic [3:0]         status_in,
    output logic               valid_out,
    output logic [DATA_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  val_rn_out,
    output logic [DATA_W-1:0]  val_rm_out,
    output logic [SHOP_W-1:0]  shift_operand_out,
    output logic               imm_out,
    output logic [IMM24_W-1:0] imm24_out,
    output logic [3:0]         dest_out,
    output logic [3:0]         src1_out,
    output logic [3:0]         src2_out,
    output logic [3:0]         exe_cmd_out,
    output logic               mem_r_out,
    output logic               mem_w_out,
    output logic               wb_en_out,
    output logic               b_out,
    output logic               s_out,
    output logic [3:0]         status_out
);

    localparam logic [1:0] SEL_LOAD  = 2'd0;
    localparam logic [1:0] SEL_HOLD  = 2'd1;
    localparam logic [1:0] SEL_CLEAR = 2'd2;

    logic               r_valid;
    logic [DATA_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_val_rn;
    logic [DATA_W-1:0]  r_val_rm;
    logic [SHOP_W-1:0]  r_shift_operand;
    logic               r_imm;
    logic [IMM24_W-1:0] r_imm24;
    logic [3:0]         r_dest;
    logic [3:0]         r_src1;
    logic [3:0]         r_src2;
    logic [3:0]         r_exe_cmd;
    logic               r_mem_r;
    logic               r_mem_w;
    logic               r_wb_en;
    logic               r_b;
    logic               r_s;
    logic [3:0]         r_status;

    logic [1:0]         w_sel;

    // Flush must win over freeze so a squashed instruction never lingers in a stall.
    always_comb begin
        w_sel = SEL_LOAD;
        if (flush) begin
            w_sel = SEL_CLEAR;
        end else if (freeze) begin
            w_sel = SEL_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid         <= 1'b0;
            r_pc            <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_shift_operand <= '0;
            r_imm           <= 1'b0;
            r_imm24         <= '0;
            r_dest          <= '0;
            r_src1          <= '0;
            r_src2          <= '0;
            r_exe_cmd       <= '0;
            r_mem_r         <= 1'b0;
            r_mem_w         <= 1'b0;
            r_wb_en         <= 1'b0;
            r_b             <= 1'b0;
            r_s             <= 1'b0;
            r_status        <= '0;
        end else begin
            case (w_sel)
                SEL_CLEAR: begin
                    r_valid         <= 1'b0;
                    r_pc            <= '0;
                    r_val_rn        <= '0;
                    r_val_rm        <= '0;
                    r_shift_operand <= '0;
                    r_imm           <= 1'b0;
                    r_imm24         <= '0;
                    r_dest          <= '0;
                    r_src1          <= '0;
                    r_src2          <= '0;
                    r_exe_cmd       <= '0;
                    r_mem_r         <= 1'b0;
                    r_mem_w         <= 1'b0;
                    r_wb_en         <= 1'b0;
                    r_b             <= 1'b0;
                    r_s             <= 1'b0;
                    r_status        <= '0;
                end
                SEL_LOAD: begin
                    r_valid         <= valid_in;
                    r_pc            <= pc_in;
                    r_val_rn        <= val_rn_in;
                    r_val_rm        <= val_rm_in;
                    r_shift_operand <= shift_operand_in;
                    r_imm           <= imm_in;
                    r_imm24         <= imm24_in;
                    r_dest          <= dest_in;
                    r_src1          <= src1_in;
                    r_src2          <= src2_in;
                    r_exe_cmd       <= exe_cmd_in;
                    r_mem_r         <= mem_r_in;
                    r_mem_w         <= mem_w_in;
                    r_wb_en         <= wb_en_in;
                    r_b             <= b_in;
                    r_s             <= s_in;
                    r_status        <= status_in;
                end
                default: ; // hold: every field keeps its value
            endcase
        end
    end

    assign valid_out         = r_valid;
    assign pc_out            = r_pc;
    assign val_rn_out        = r_val_rn;
    assign val_rm_out        = r_val_rm;
    assign shift_operand_out = r_shift_operand;
    assign imm_out           = r_imm;
    assign imm24_out         = r_imm24;
    assign dest_out          = r_dest;
    assign src1_out          = r_src1;
    assign src2_out          = r_src2;
    assign exe_cmd_out       = r_exe_cmd;
    assign mem_r_out         = r_mem_r;
    assign mem_w_out         = r_mem_w;
    assign wb_en_out         = r_wb_en;
    assign b_out             = r_b;
    assign s_out             = r_s;
    assign status_out        = r_status;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// Testbench for id_ex_reg: directed scenarios plus randomized load/hold/bubble
// traffic checked against a per-edge behavioural model of the register bundle.
module tb_id_ex_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [11:0] shop;
        logic        imm;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  cmd;
        logic        mem_r;
        logic        mem_w;
        logic        wb_en;
        logic        b;
        logic        s;
        logic [3:0]  status;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    freeze = 1'b0;
    logic    flush = 1'b0;
    bundle_t in_b = '0;
    bundle_t out_b;
    bundle_t exp_b = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .flush             (flush),
        .valid_in          (in_b.valid),
        .pc_in             (in_b.pc),
        .val_rn_in         (in_b.rn),
        .val_rm_in         (in_b.rm),
        .shift_operand_in  (in_b.shop),
        .imm_in            (in_b.imm),
        .imm24_in          (in_b.imm24),
        .dest_in           (in_b.dest),
        .src1_in           (in_b.src1),
        .src2_in           (in_b.src2),
        .exe_cmd_in        (in_b.cmd),
        .mem_r_in          (in_b.mem_r),
        .mem_w_in          (in_b.mem_w),
        .wb_en_in          (in_b.wb_en),
        .b_in              (in_b.b),
        .s_in              (in_b.s),
        .status_in         (in_b.status),
        .valid_out         (out_b.valid),
        .pc_out            (out_b.pc),
        .val_rn_out        (out_b.rn),
        .val_rm_out        (out_b.rm),
        .shift_operand_out (out_b.shop),
        .imm_out           (out_b.imm),
        .imm24_out         (out_b.imm24),
        .dest_out          (out_b.dest),
        .src1_out          (out_b.src1),
        .src2_out          (out_b.src2),
        .exe_cmd_out       (out_b.cmd),
        .mem_r_out         (out_b.mem_r),
        .mem_w_out         (out_b.mem_w),
        .wb_en_out         (out_b.wb_en),
        .b_out             (out_b.b),
        .s_out             (out_b.s),
        .status_out        (out_b.status)
    );

    function automatic bundle_t rand_bundle();
        bundle_t v;
        v.valid  = 1'b1;
        v.pc     = $urandom;
        v.rn     = $urandom;
        v.rm     = $urandom;
        v.shop   = 12'($urandom);
        v.imm    = 1'($urandom);
        v.imm24  = 24'($urandom);
        v.dest   = 4'($urandom);
        v.src1   = 4'($urandom);
        v.src2   = 4'($urandom);
        v.cmd    = 4'($urandom);
        v.mem_r  = 1'($urandom);
        v.mem_w  = 1'($urandom);
        v.wb_en  = 1'($urandom);
        v.b      = 1'($urandom);
        v.s      = 1'($urandom);
        v.status = 4'($urandom);
        return v;
    endfunction

    // One clock edge: advance the model from the inputs present at the edge, then compare.
    task automatic tick(input string name);
        @(posedge clk);
        if (!rst)        exp_b = '0;
        else if (flush)  exp_b = '0;
        else if (!freeze) exp_b = in_b;
        #1;
        n_checks++;
        if (out_b !== exp_b) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, out_b, exp_b);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (out_b !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected 0", out_b);
        end
        @(negedge clk);
        rst = 1'b1;
        in_b = rand_bundle();
        tick("reset_preload");
        #2;
        rst = 1'b0;
        #1;
        exp_b = '0;
        n_checks++;
        if (out_b !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 0", out_b);
        end
        tick("reset_held");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load();
        bundle_t v;
        v = '0;
        v.pc    = 32'h0000_0010;
        v.rm    = 32'h8000_0001;
        v.shop  = 12'hF41;
        v.imm   = 1'b0;
        v.wb_en = 1'b1;
        v.valid = 1'b1;
        in_b = v;
        tick("load_first");
        n_checks++;
        if (out_b.valid !== 1'b1 || out_b.rm !== 32'h8000_0001 || out_b.shop !== 12'hF41) begin
            n_fail++;
            $display("FAIL load_fields: got valid=%b rm=%h shop=%h expected 1 80000001 f41",
                     out_b.valid, out_b.rm, out_b.shop);
        end
        in_b = rand_bundle();
        tick("load_follow");
    endtask

    task automatic test_freeze();
        in_b = rand_bundle();
        in_b.dest = 4'd3;
        tick("freeze_load_a");
        in_b = rand_bundle();
        in_b.dest = 4'd7;
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("freeze_hold");
            n_checks++;
            if (out_b.dest !== 4'd3) begin
                n_fail++;
                $display("FAIL freeze_dest: got %0d expected 3", out_b.dest);
            end
        end
        freeze = 1'b0;
        tick("freeze_release");
        n_checks++;
        if (out_b.dest !== 4'd7) begin
            n_fail++;
            $display("FAIL freeze_release_dest: got %0d expected 7", out_b.dest);
        end
    endtask

    task automatic test_flush();
        in_b = rand_bundle();
        in_b.mem_w = 1'b1;
        in_b.rn    = 32'hDEAD_BEEF;
        tick("flush_store");
        in_b = rand_bundle();
        flush = 1'b1;
        tick("flush_bubble");
        n_checks++;
        if (out_b.mem_w !== 1'b0 || out_b.valid !== 1'b0 || out_b.rn !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_fields: got mem_w=%b valid=%b rn=%h expected 0 0 0",
                     out_b.mem_w, out_b.valid, out_b.rn);
        end
        flush = 1'b0;
        in_b = rand_bundle();
        tick("flush_next_load");
    endtask

    task automatic test_flush_freeze();
        in_b = rand_bundle();
        tick("flfr_load");
        flush  = 1'b1;
        freeze = 1'b1;
        in_b = rand_bundle();
        tick("flfr_bubble");
        n_checks++;
        if (out_b !== '0) begin
            n_fail++;
            $display("FAIL flfr_zero: got %h expected 0", out_b);
        end
        flush  = 1'b0;
        freeze = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen[$];
        for (int i = 1; i <= 8; i++) begin
            in_b = rand_bundle();
            in_b.pc = 32'(4 * i);
            tick("b2b_step");
            seen.push_back(out_b.pc);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (seen[i] !== 32'(4 * (i + 1))) begin
                n_fail++;
                $display("FAIL b2b_seq[%0d]: got %0d expected %0d", i, seen[i], 4 * (i + 1));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_b   = rand_bundle();
            in_b.valid = 1'($urandom);
            flush  = ($urandom_range(0, 9) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            tick("random");
        end
        flush  = 1'b0;
        freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_freeze();
        test_flush();
        test_flush_freeze();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
